// File: rtl/vending_change_dispenser.sv
// Change dispenser: pays out an amount owed (half-yuan units) through a one-yuan
// and a half-yuan hopper. Define DISPENSE_RETRY_EN to allow one re-drive per coin.
module vending_change_dispenser #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pi_req,
  input  logic [3:0] pi_amount,
  input  logic       pi_hopper_ack,
  input  logic       pi_clear,
  output logic       po_drive_one,
  output logic       po_drive_half,
  output logic       po_busy,
  output logic       po_done,
  output logic       po_fault,
  output logic [3:0] po_remaining
);

  localparam int CNT_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_DRIVE    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_DONE     = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             coin_one, coin_one_d;
  logic [3:0]       remaining_d;
  logic             drive_one_d, drive_half_d, busy_d, done_d, fault_d;

`ifdef DISPENSE_RETRY_EN
  // Set once the current coin has used up its single re-drive.
  logic retried, retried_d;
`endif

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    state_d     = state;
    cnt_d       = cnt;
    coin_one_d  = coin_one;
    remaining_d = po_remaining;
`ifdef DISPENSE_RETRY_EN
    retried_d   = retried;
`endif

    case (state)
      S_IDLE: begin
        if (pi_req) begin
          remaining_d = pi_amount;
          state_d     = S_SELECT;
        end
      end

      S_SELECT: begin
        cnt_d = '0;
`ifdef DISPENSE_RETRY_EN
        retried_d = 1'b0;
`endif
        if (po_remaining == 4'd0) begin
          state_d = S_DONE;
        end else begin
          coin_one_d = (po_remaining >= 4'd2);
          state_d    = S_DRIVE;
        end
      end

      S_DRIVE: begin
        if (cnt == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_ACK;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      S_WAIT_ACK: begin
        // An acknowledge in the last waiting cycle still counts the coin.
        if (pi_hopper_ack) begin
          remaining_d = po_remaining - (coin_one ? 4'd2 : 4'd1);
          state_d     = S_SELECT;
        end else if (cnt == TIMEOUT_LAST) begin
`ifdef DISPENSE_RETRY_EN
          if (!retried) begin
            retried_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_DRIVE;
          end else begin
            state_d = S_FAULT;
          end
`else
          state_d = S_FAULT;
`endif
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      S_FAULT: begin
        if (pi_clear) begin
          remaining_d = 4'd0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so they can be registered
    // and still line up with the state they describe.
    busy_d       = (state_d != S_IDLE);
    drive_one_d  = (state_d == S_DRIVE) && coin_one_d;
    drive_half_d = (state_d == S_DRIVE) && !coin_one_d;
    done_d       = (state_d == S_DONE);
    fault_d      = (state_d == S_FAULT);
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      coin_one      <= 1'b0;
      po_remaining  <= 4'd0;
      po_drive_one  <= 1'b0;
      po_drive_half <= 1'b0;
      po_busy       <= 1'b0;
      po_done       <= 1'b0;
      po_fault      <= 1'b0;
`ifdef DISPENSE_RETRY_EN
      retried       <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      coin_one      <= coin_one_d;
      po_remaining  <= remaining_d;
      po_drive_one  <= drive_one_d;
      po_drive_half <= drive_half_d;
      po_busy       <= busy_d;
      po_done       <= done_d;
      po_fault      <= fault_d;
`ifdef DISPENSE_RETRY_EN
      retried       <= retried_d;
`endif
    end
  end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Self-checking bench for vending_change_dispenser: directed scenarios plus
// randomized payouts against a transaction-level model of the payout rules.
module tb_vending_change_dispenser;

  localparam int PULSE = 4;
  localparam int TMO   = 16;
  localparam int NOACK = 99;
`ifdef DISPENSE_RETRY_EN
  localparam int TRIES = 2;
`else
  localparam int TRIES = 1;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pi_req = 1'b0;
  logic [3:0] pi_amount = 4'd0;
  logic       pi_hopper_ack = 1'b0;
  logic       pi_clear = 1'b0;
  logic       po_drive_one, po_drive_half, po_busy, po_done, po_fault;
  logic [3:0] po_remaining;

  vending_change_dispenser #(.PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_req(pi_req), .pi_amount(pi_amount),
    .pi_hopper_ack(pi_hopper_ack), .pi_clear(pi_clear), .po_drive_one(po_drive_one),
    .po_drive_half(po_drive_half), .po_busy(po_busy), .po_done(po_done),
    .po_fault(po_fault), .po_remaining(po_remaining)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Ack delay per drive pulse, in WAIT cycles after the pulse ends (>= TMO: none in time).
  int plan_q[$];
  int one_lens[$], half_lens[$], rem_trace[$];
  int done_cnt = 0, overlap_cnt = 0, one_run = 0, half_run = 0, ack_cd = -1, d_pop;
  logic prev_drive = 1'b0;
  logic [3:0] prev_rem = 4'd0;

  // Expected results from the model
  int e_one, e_half, e_fault, e_done, e_rem;
  int e_trace[$];

  // Hopper emulator and output monitor, sampling on the falling edge.
  always @(negedge sys_clk) begin
    pi_hopper_ack = 1'b0;
    if (ack_cd == 0) begin
      pi_hopper_ack = 1'b1;
      ack_cd = -1;
    end else if (ack_cd > 0) begin
      ack_cd--;
    end
    if (prev_drive && !po_drive_one && !po_drive_half) begin
      d_pop = (plan_q.size() > 0) ? plan_q.pop_front() : NOACK;
      if (d_pop == 0) pi_hopper_ack = 1'b1;
      else if (d_pop < NOACK) ack_cd = d_pop - 1;
    end
    prev_drive = po_drive_one | po_drive_half;
    if (po_drive_one) one_run++;
    else if (one_run > 0) begin one_lens.push_back(one_run); one_run = 0; end
    if (po_drive_half) half_run++;
    else if (half_run > 0) begin half_lens.push_back(half_run); half_run = 0; end
    if (po_drive_one && po_drive_half) overlap_cnt++;
    if (po_done) done_cnt++;
    if (po_remaining != prev_rem) rem_trace.push_back(int'(po_remaining));
    prev_rem = po_remaining;
    if (!sys_rst_n) ack_cd = -1;
  end

  // Coins are paid largest first; each coin gets TRIES drives, each drive consumes
  // one plan entry; an ack within the timeout window pays the coin.
  task automatic model(input int a);
    int rem, idx, coin, d;
    bit acked;
    rem = a; idx = 0; e_one = 0; e_half = 0; e_fault = 0;
    e_trace.delete();
    if (a > 0) e_trace.push_back(a);
    while (rem > 0 && e_fault == 0) begin
      coin = (rem >= 2) ? 2 : 1;
      acked = 1'b0;
      for (int t = 0; t < TRIES && !acked; t++) begin
        if (coin == 2) e_one++; else e_half++;
        d = (idx < plan_q.size()) ? plan_q[idx] : NOACK;
        idx++;
        if (d < TMO) acked = 1'b1;
      end
      if (acked) begin
        rem -= coin;
        e_trace.push_back(rem);
      end else begin
        e_fault = 1;
      end
    end
    e_rem  = rem;
    e_done = (e_fault != 0) ? 0 : 1;
    if (e_fault != 0) e_trace.push_back(0);
  endtask

  task automatic clear_log();
    one_lens.delete(); half_lens.delete(); rem_trace.delete();
    done_cnt = 0; overlap_cnt = 0;
    prev_rem = po_remaining;
  endtask

  task automatic issue_req(input logic [3:0] a);
    @(negedge sys_clk); #1;
    pi_req = 1'b1; pi_amount = a;
    @(negedge sys_clk); #1;
    pi_req = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge sys_clk); #1;
      if (!po_busy || po_fault) ok = 1'b1;
    end
  endtask

  task automatic wait_drive(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge sys_clk); #1;
      if ((po_drive_one | po_drive_half) == level) ok = 1'b1;
    end
  endtask

  task automatic start_txn(input int a);
    @(negedge sys_clk); #1;
    clear_log();
    model(a);
    issue_req(4'(a));
  endtask

  task automatic finish_txn(input string name);
    bit ok, same;
    int bad_len;
    wait_end(1000, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL %s end_timeout: got busy=%0d want idle or fault", name, po_busy); end
    n_cmp++;
    if (po_fault !== 1'(e_fault)) begin n_err++; $display("FAIL %s fault: got %0d want %0d", name, po_fault, e_fault); end
    if (po_fault) begin
      n_cmp++;
      if (po_remaining !== 4'(e_rem)) begin n_err++; $display("FAIL %s fault_remaining: got %0d want %0d", name, po_remaining, e_rem); end
      pi_clear = 1'b1;
      @(negedge sys_clk); #1;
      pi_clear = 1'b0;
      n_cmp++;
      if ({po_busy, po_fault, po_remaining} !== 6'd0) begin
        n_err++; $display("FAIL %s after_clear: got busy=%0d fault=%0d rem=%0d want 0/0/0", name, po_busy, po_fault, po_remaining);
      end
    end
    @(negedge sys_clk); #1;
    n_cmp++;
    if (done_cnt !== e_done) begin n_err++; $display("FAIL %s done_pulses: got %0d want %0d", name, done_cnt, e_done); end
    n_cmp++;
    if (one_lens.size() !== e_one) begin n_err++; $display("FAIL %s one_pulses: got %0d want %0d", name, one_lens.size(), e_one); end
    n_cmp++;
    if (half_lens.size() !== e_half) begin n_err++; $display("FAIL %s half_pulses: got %0d want %0d", name, half_lens.size(), e_half); end
    bad_len = 0;
    foreach (one_lens[i]) if (one_lens[i] != PULSE) bad_len++;
    foreach (half_lens[i]) if (half_lens[i] != PULSE) bad_len++;
    n_cmp++;
    if (bad_len !== 0) begin n_err++; $display("FAIL %s pulse_len: got %0d wrong-length pulses want 0", name, bad_len); end
    n_cmp++;
    if (overlap_cnt !== 0) begin n_err++; $display("FAIL %s overlap: got %0d cycles both drives high want 0", name, overlap_cnt); end
    same = (rem_trace.size() == e_trace.size());
    if (same) foreach (e_trace[i]) if (rem_trace[i] != e_trace[i]) same = 1'b0;
    n_cmp++;
    if (!same) begin n_err++; $display("FAIL %s remaining_trace: got %p want %p", name, rem_trace, e_trace); end
    plan_q.delete();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({po_drive_one, po_drive_half, po_busy, po_done, po_fault, po_remaining} !== 9'd0) begin
      n_err++; $display("FAIL reset_outputs: got %b want all zero",
        {po_drive_one, po_drive_half, po_busy, po_done, po_fault, po_remaining});
    end
    @(negedge sys_clk); #1;
    sys_rst_n = 1'b1;
    pi_clear = 1'b1;
    @(negedge sys_clk); #1;
    pi_clear = 1'b0;
    n_cmp++;
    if ({po_busy, po_fault} !== 2'b00) begin n_err++; $display("FAIL clear_in_idle: got busy=%0d fault=%0d want 0/0", po_busy, po_fault); end
  endtask

  task automatic test_three();
    plan_q = '{2, 2};
    start_txn(3);
    n_cmp++;
    if ({po_busy, po_drive_one, po_remaining} !== {1'b1, 1'b0, 4'd3}) begin
      n_err++; $display("FAIL three_select: got busy=%0d drive=%0d rem=%0d want 1/0/3", po_busy, po_drive_one, po_remaining);
    end
    @(negedge sys_clk); #1;
    n_cmp++;
    if ({po_drive_one, po_drive_half} !== 2'b10) begin
      n_err++; $display("FAIL three_drive_start: got one=%0d half=%0d want 1/0", po_drive_one, po_drive_half);
    end
    finish_txn("three");
  endtask

  task automatic test_zero();
    @(negedge sys_clk); #1;
    clear_log();
    issue_req(4'd0);
    n_cmp++;
    if ({po_busy, po_done} !== 2'b10) begin n_err++; $display("FAIL zero_c1: got busy=%0d done=%0d want 1/0", po_busy, po_done); end
    @(negedge sys_clk); #1;
    n_cmp++;
    if ({po_busy, po_done} !== 2'b11) begin n_err++; $display("FAIL zero_c2: got busy=%0d done=%0d want 1/1", po_busy, po_done); end
    @(negedge sys_clk); #1;
    n_cmp++;
    if ({po_busy, po_done} !== 2'b00) begin n_err++; $display("FAIL zero_c3: got busy=%0d done=%0d want 0/0", po_busy, po_done); end
    n_cmp++;
    if (one_lens.size() + half_lens.size() !== 0) begin
      n_err++; $display("FAIL zero_pulses: got %0d want 0", one_lens.size() + half_lens.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    plan_q = '{NOACK, NOACK};
    @(negedge sys_clk); #1;
    clear_log();
    issue_req(4'd2);
    for (int r = 0; r < TRIES; r++) begin
      wait_drive(1'b1, 20, ok);
      wait_drive(1'b0, 20, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL timeout_pulse%0d: got no completed drive pulse want one", r); end
      repeat (TMO - 1) @(negedge sys_clk);
      #1;
      n_cmp++;
      if (po_fault !== 1'b0) begin n_err++; $display("FAIL timeout_early%0d: got fault=%0d want 0", r, po_fault); end
    end
    @(negedge sys_clk); #1;
    n_cmp++;
    if ({po_fault, po_remaining} !== {1'b1, 4'd2}) begin
      n_err++; $display("FAIL timeout_fault: got fault=%0d rem=%0d want 1/2", po_fault, po_remaining);
    end
    pi_clear = 1'b1;
    @(negedge sys_clk); #1;
    pi_clear = 1'b0;
    n_cmp++;
    if ({po_busy, po_fault, po_remaining} !== 6'd0) begin
      n_err++; $display("FAIL timeout_clear: got busy=%0d fault=%0d rem=%0d want 0/0/0", po_busy, po_fault, po_remaining);
    end
    plan_q.delete();
  endtask

  task automatic test_busy_req();
    plan_q = '{1, 3};
    start_txn(4);
    repeat (2) @(negedge sys_clk);
    #1;
    pi_req = 1'b1; pi_amount = 4'd7;
    repeat (8) @(negedge sys_clk);
    #1;
    pi_req = 1'b0;
    finish_txn("busy_req");
  endtask

  task automatic test_reset_mid();
    bit ok;
    plan_q = '{NOACK};
    @(negedge sys_clk); #1;
    clear_log();
    issue_req(4'd6);
    wait_drive(1'b1, 10, ok);
    #2;
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({po_drive_one, po_drive_half, po_busy, po_remaining} !== 7'd0) begin
      n_err++; $display("FAIL reset_mid: got one=%0d half=%0d busy=%0d rem=%0d want all 0",
        po_drive_one, po_drive_half, po_busy, po_remaining);
    end
    @(negedge sys_clk); #1;
    sys_rst_n = 1'b1;
    plan_q.delete();
  endtask

  task automatic test_random();
    int r, a;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 20; k++) begin
        r = $urandom_range(0, 19);
        plan_q.push_back(r < 16 ? r % 5 : (r == 16 ? TMO - 1 : (r == 17 ? TMO : NOACK)));
      end
      a = $urandom_range(0, 15);
      start_txn(a);
      finish_txn($sformatf("rand%0d_amt%0d", n, a));
    end
  endtask

  initial begin
    test_reset();
    test_three();
    test_zero();
    test_timeout();
    plan_q = '{TMO - 1};
    start_txn(2);
    finish_txn("ack_at_timeout");
    plan_q = '{NOACK, 1};
    start_txn(2);
    finish_txn("retry_recover");
    test_busy_req();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
